// File: rtl/bcd_entry_pkg.sv
// Shared definitions for the BCD keypad entry block.
//   NUM_KEYS / BCD_W : key-line count and BCD nibble width
//   state_e          : entry FSM states
//   encode()         : key vector -> {valid, digit}
package bcd_entry_pkg;

    localparam int NUM_KEYS = 10;
    localparam int BCD_W    = 4;

    typedef enum logic [1:0] {
        IDLE,
        EMIT,
        RELEASE
    } state_e;

    // Ascending scan, so the last set bit seen is the highest index.
    // A single key is always valid. Several keys are valid only when
    // highest_wins is set. No key is never valid.
    function automatic logic [BCD_W:0] encode(input logic [NUM_KEYS-1:0] keys,
                                              input logic                highest_wins);
        logic [BCD_W-1:0] idx;
        int               n;
        idx = '0;
        n   = 0;
        for (int k = 0; k < NUM_KEYS; k++) begin
            if (keys[k]) begin
                idx = BCD_W'(k);
                n++;
            end
        end
        return {(n == 1) || (highest_wins && (n > 1)), idx};
    endfunction

endpackage

// File: rtl/bcd_keypad_entry_debouncer.sv
// sw_debouncer: 2-FF synchroniser plus a stable-time debouncer on a bus.
//   clk, rst_n : clock, async active-low reset
//   in_raw     : asynchronous raw lines
//   db         : debounced vector. It takes the synchronised value once that
//                value has held for DEBOUNCE_CYCLES edges.
module sw_debouncer #(
    parameter int WIDTH           = 10,
    parameter int DEBOUNCE_CYCLES = 1000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_raw,
    output logic [WIDTH-1:0] db
);

    localparam int              CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync1_q, sync1_d;
    logic [WIDTH-1:0] sync2_q, sync2_d;
    logic [WIDTH-1:0] db_q, db_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        sync1_d = in_raw;
        sync2_d = sync1_q;
        db_d    = db_q;
        cnt_d   = '0;
        // sync1 != sync2 means sync2 changes on this edge, so the stable run
        // starts again from zero. An edge with sync2 stable and different
        // from db counts toward acceptance.
        if ((sync1_q == sync2_q) && (sync2_q != db_q)) begin
            if (cnt_q == CNT_LAST) begin
                db_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            db_q    <= '0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            db_q    <= db_d;
            cnt_q   <= cnt_d;
        end
    end

    assign db = db_q;

endmodule

// File: rtl/bcd_keypad_entry.sv
// bcd_keypad_entry: debounced 10-key decimal pad to BCD digit stream and
// shift-in entry register.
//   clk, rst_n        : clock, async active-low reset
//   in[9:0]           : raw key lines, bit k = decimal k
//   clear             : sync clear of digits/digit_count
//   out_valid/ready   : handshake for out_digit (one digit per press)
//   digits            : entry register, newest digit in [3:0]
//   digit_count       : digits entered, saturating at NUM_DIGITS
//   error / overflow  : one-cycle pulses (multi-key reject / oldest dropped)
module bcd_keypad_entry
    import bcd_entry_pkg::*;
#(
    parameter int NUM_DIGITS      = 4,
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int MULTI_KEY_MODE  = 0
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [NUM_KEYS-1:0]               in,
    input  logic                              clear,
    input  logic                              out_ready,
    output logic                              out_valid,
    output logic [BCD_W-1:0]                  out_digit,
    output logic [BCD_W*NUM_DIGITS-1:0]       digits,
    output logic [$clog2(NUM_DIGITS+1)-1:0]   digit_count,
    output logic                              error,
    output logic                              overflow
);

    localparam int DIG_W = BCD_W * NUM_DIGITS;
    localparam int CNT_W = $clog2(NUM_DIGITS + 1);

    logic [NUM_KEYS-1:0] db;
    logic [BCD_W:0]      enc;
    logic                enc_valid;
    logic [BCD_W-1:0]    enc_digit;
    logic                key_down, take, reject, accept;

    state_e           state_q, state_d;
    logic             out_valid_q, out_valid_d;
    logic [BCD_W-1:0] out_digit_q, out_digit_d;
    logic [DIG_W-1:0] digits_q, digits_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             error_q, error_d;
    logic             overflow_q, overflow_d;

    sw_debouncer #(
        .WIDTH          (NUM_KEYS),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
        .clk   (clk),
        .rst_n (rst_n),
        .in_raw(in),
        .db    (db)
    );

    assign enc                    = encode(db, MULTI_KEY_MODE != 0);
    assign {enc_valid, enc_digit} = enc;
    assign key_down               = |db;
    assign take                   = (state_q == IDLE) && key_down && enc_valid;
    assign reject                 = (state_q == IDLE) && key_down && !enc_valid;
    assign accept                 = (state_q == EMIT) && out_valid_q && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            out_digit_q <= '0;
            digits_q    <= '0;
            count_q     <= '0;
            error_q     <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            out_digit_q <= out_digit_d;
            digits_q    <= digits_d;
            count_q     <= count_d;
            error_q     <= error_d;
            overflow_q  <= overflow_d;
        end
    end

    // A press is consumed once. Any key state is ignored until all keys are
    // seen released in RELEASE. This gives one digit per hold.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (key_down) state_d = enc_valid ? EMIT : RELEASE;
            EMIT:    if (accept) state_d = RELEASE;
            RELEASE: if (!key_down) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_digit_d = out_digit_q;
        digits_d    = digits_q;
        count_d     = count_q;
        error_d     = reject;
        overflow_d  = 1'b0;
        if (take) begin
            out_valid_d = 1'b1;
            out_digit_d = enc_digit;
            digits_d    = (digits_q << BCD_W) | DIG_W'(enc_digit);
            if (count_q < CNT_W'(NUM_DIGITS)) begin
                count_d = count_q + CNT_W'(1);
            end else begin
                // A clear on the same edge empties the register anyway, so
                // no digit is reported as lost.
                overflow_d = !clear;
            end
        end
        if (accept) begin
            out_valid_d = 1'b0;
        end
        // clear wins over a coincident shift. The digit is still offered on out_digit.
        if (clear) begin
            digits_d = '0;
            count_d  = '0;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_digit   = out_digit_q;
    assign digits      = digits_q;
    assign digit_count = count_q;
    assign error       = error_q;
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_bcd_keypad_entry.sv
// Bench for bcd_keypad_entry. dut[0] runs multi-key mode 0 and dut[1] runs
// mode 1. Both use DEBOUNCE_CYCLES=4 and NUM_DIGITS=4, and both share one
// stimulus stream. The stimulus pushes the expected digit and the cycle
// out_valid should rise into one queue per DUT. A monitor pops and compares
// on every handshake.
module tb_bcd_keypad_entry;

    typedef struct {
        logic [3:0] d;
        int         rise;
    } exp_t;

    logic             clk = 0;
    logic             rst_n;
    logic [9:0]       kin;
    logic             clear;
    logic             out_ready;
    logic [1:0]       ov;
    logic [1:0][3:0]  od;
    logic [1:0][15:0] dg;
    logic [1:0][2:0]  dc;
    logic [1:0]       er;
    logic [1:0]       of;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    exp_t q0[$];
    exp_t q1[$];
    int   err_cnt[2];
    int   ovf_cnt[2];
    int   rise_c[2];
    logic [3:0] held_d[2];
    logic [1:0] pv;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    bcd_keypad_entry #(.NUM_DIGITS(4), .DEBOUNCE_CYCLES(4), .MULTI_KEY_MODE(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .in(kin), .clear(clear), .out_ready(out_ready),
        .out_valid(ov[0]), .out_digit(od[0]), .digits(dg[0]), .digit_count(dc[0]),
        .error(er[0]), .overflow(of[0])
    );

    bcd_keypad_entry #(.NUM_DIGITS(4), .DEBOUNCE_CYCLES(4), .MULTI_KEY_MODE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in(kin), .clear(clear), .out_ready(out_ready),
        .out_valid(ov[1]), .out_digit(od[1]), .digits(dg[1]), .digit_count(dc[1]),
        .error(er[1]), .overflow(of[1])
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor
    always @(negedge clk) begin
        if (!rst_n) begin
            pv = '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                exp_t e;
                bit   have;
                if (ov[i] && !pv[i]) begin
                    rise_c[i] = cyc;
                    held_d[i] = od[i];
                end else if (ov[i]) begin
                    chk($sformatf("dut%0d_stable_digit", i), od[i], held_d[i]);
                end
                if (ov[i] && out_ready) begin
                    have = 0;
                    if (i == 0 && q0.size() > 0) begin e = q0.pop_front(); have = 1; end
                    if (i == 1 && q1.size() > 0) begin e = q1.pop_front(); have = 1; end
                    if (!have) begin
                        checks++;
                        errors++;
                        $display("FAIL dut%0d_unexpected_out: got digit %0d expected none (cycle %0d)",
                                 i, od[i], cyc);
                    end else begin
                        chk($sformatf("dut%0d_digit", i), od[i], e.d);
                        chk($sformatf("dut%0d_latency", i), rise_c[i], e.rise);
                    end
                end
                if (er[i]) err_cnt[i]++;
                if (of[i]) begin
                    ovf_cnt[i]++;
                    chk($sformatf("dut%0d_ovf_on_shift", i), ov[i], 1);
                end
                pv[i] = ov[i];
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // d0/d1 = -1 means that DUT must emit nothing for this press.
    task automatic press(input logic [9:0] v, input int hold, input int d0, input int d1);
        if (d0 >= 0) q0.push_back('{d: 4'(d0), rise: cyc + 7});
        if (d1 >= 0) q1.push_back('{d: 4'(d1), rise: cyc + 7});
        kin = v;
        tick(hold);
        kin = '0;
        tick(10);
    endtask

    task automatic chk_regs(input string nm, input logic [15:0] d0, input logic [2:0] c0,
                            input logic [15:0] d1, input logic [2:0] c1);
        chk({nm, "_dut0_digits"}, dg[0], d0);
        chk({nm, "_dut0_count"}, dc[0], c0);
        chk({nm, "_dut1_digits"}, dg[1], d1);
        chk({nm, "_dut1_count"}, dc[1], c1);
    endtask

    task automatic do_clear();
        clear = 1;
        tick(1);
        clear = 0;
    endtask

    task automatic chk_zero(input string nm);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("%s_dut%0d_valid", nm, i), ov[i], 0);
            chk($sformatf("%s_dut%0d_digit", nm, i), od[i], 0);
            chk($sformatf("%s_dut%0d_digits", nm, i), dg[i], 0);
            chk($sformatf("%s_dut%0d_count", nm, i), dc[i], 0);
            chk($sformatf("%s_dut%0d_error", nm, i), er[i], 0);
            chk($sformatf("%s_dut%0d_ovf", nm, i), of[i], 0);
        end
    endtask

    initial begin
        logic [9:0] v;
        err_cnt = '{0, 0};
        ovf_cnt = '{0, 0};
        pv      = '0;
        rst_n     = 0;
        kin       = '0;
        clear     = 0;
        out_ready = 1;
        tick(3);
        chk_zero("reset");
        rst_n = 1;
        tick(2);

        // Keys 0..9 in order. Each press gives one digit, 7 edges after the press.
        for (int k = 0; k < 10; k++) begin
            v = 10'd1 << k;
            press(v, 12, k, k);
        end
        chk_regs("seq", 16'h6789, 3'd4, 16'h6789, 3'd4);
        chk("seq_dut0_ovf_pulses", ovf_cnt[0], 6);
        chk("seq_dut1_ovf_pulses", ovf_cnt[1], 6);

        do_clear();
        chk_regs("clear", 16'h0000, 3'd0, 16'h0000, 3'd0);

        // Keys 2 and 9 together. Mode 0 rejects the press; mode 1 takes 9.
        press(10'b10_0000_0100, 12, -1, 9);
        chk("multi_dut0_error_pulses", err_cnt[0], 1);
        chk("multi_dut1_error_pulses", err_cnt[1], 0);
        chk_regs("multi", 16'h0000, 3'd0, 16'h0009, 3'd1);

        // Key 3 glitch held 3 cycles, shorter than the debounce time.
        press(10'b00_0000_1000, 3, -1, -1);
        chk_regs("glitch", 16'h0000, 3'd0, 16'h0009, 3'd1);

        // Overflow on the 5th digit.
        do_clear();
        for (int k = 1; k <= 5; k++) begin
            v = 10'd1 << k;
            press(v, 12, k, k);
        end
        chk_regs("ovf", 16'h2345, 3'd4, 16'h2345, 3'd4);
        chk("ovf_dut0_pulses", ovf_cnt[0], 7);
        chk("ovf_dut1_pulses", ovf_cnt[1], 7);

        // Backpressure: key 7 held. out_ready stays low for 10 cycles after
        // out_valid rises. Then one transfer happens, with no repeat while
        // the key is still held.
        out_ready = 0;
        q0.push_back('{d: 4'd7, rise: cyc + 7});
        q1.push_back('{d: 4'd7, rise: cyc + 7});
        kin = 10'b00_1000_0000;
        tick(17);
        chk("bp_dut0_valid_held", ov[0], 1);
        chk("bp_dut1_valid_held", ov[1], 1);
        out_ready = 1;
        tick(12);
        chk("bp_dut0_valid_dropped", ov[0], 0);
        kin = '0;
        tick(10);
        press(10'b00_1000_0000, 12, 7, 7);
        chk_regs("bp", 16'h4577, 3'd4, 16'h4577, 3'd4);
        chk("bp_dut0_ovf_pulses", ovf_cnt[0], 9);

        // Reset during EMIT. Key 5 stays held, so it is taken again after reset.
        out_ready = 0;
        kin = 10'b00_0010_0000;
        tick(9);
        chk("emit_dut0_valid", ov[0], 1);
        rst_n = 0;
        #1;
        chk_zero("midreset");
        tick(2);
        out_ready = 1;
        q0.push_back('{d: 4'd5, rise: cyc + 7});
        q1.push_back('{d: 4'd5, rise: cyc + 7});
        rst_n = 1;
        tick(12);
        kin = '0;
        tick(10);
        chk_regs("postreset", 16'h0005, 3'd1, 16'h0005, 3'd1);

        chk("dut0_queue_drained", q0.size(), 0);
        chk("dut1_queue_drained", q1.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
